// File: rtl/sram_phase_controller_pkg.sv
// Shared definitions for the three-phase SRAM sequencer: default widths,
// phase count and the sequencer state encoding.
package sram_phase_controller_pkg;

  localparam int ADDR_W_DEF    = 11;
  localparam int DATA_W_DEF    = 32;
  // Number of SRAM phase strobes used by a write (reads stop after two).
  localparam int STROBE_PHASES = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PH1   = 3'd2,
    ST_PH2   = 3'd3,
    ST_PH3   = 3'd4,
    ST_RDCAP = 3'd5,
    ST_RESP  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/sram_phase_controller.sv
// Sequencer between the memory stage and the 2048-word three-phase SRAM.
// One request at a time: accept, present address/RNW/data for a setup
// cycle, pulse Clock1 and Clock2, then either Clock3 (write) or an OE-low
// capture cycle (read), and finally hold the response until it is taken.
module sram_phase_controller
  import sram_phase_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr,
  output logic [ADDR_W-1:0] SramAdx,
  output logic              SramRNW,
  output logic              SramOE,
  output logic              SramClk1,
  output logic              SramClk2,
  output logic              SramClk3,
  inout  wire  [DATA_W-1:0] SramData
);

  seq_state_t        state_reg;
  logic              write_reg;
  logic              drive_reg;
  logic [DATA_W-1:0] wdata_reg;

  // The bus is driven straight from registers; drive_reg is only set for
  // writes and is cleared before OE could ever go low.
  assign SramData = drive_reg ? wdata_reg : {DATA_W{1'bz}};

  // Write-data latch; its contents only matter while drive_reg is set,
  // so it carries no reset.
  always_ff @(posedge Clock) begin
    if (state_reg == ST_IDLE && ReqValid && ReqReady) begin
      wdata_reg <= ReqData;
    end
  end

  // Sequencer FSM with all SRAM-side and response-side outputs registered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      write_reg <= 1'b0;
      drive_reg <= 1'b0;
      ReqReady  <= 1'b1;
      RspValid  <= 1'b0;
      RspData   <= '0;
      RspErr    <= 1'b0;
      SramAdx   <= '0;
      SramRNW   <= 1'b1;
      SramOE    <= 1'b1;
      SramClk1  <= 1'b0;
      SramClk2  <= 1'b0;
      SramClk3  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ReqValid && ReqReady) begin
            write_reg <= ReqWrite;
            // The top address bit is the SRAM's internal half-select;
            // it is never driven, only reported back as an error.
            SramAdx   <= {1'b0, ReqAddr[ADDR_W-2:0]};
            RspErr    <= ReqAddr[ADDR_W-1];
            RspData   <= '0;
            SramRNW   <= ~ReqWrite;
            drive_reg <= ReqWrite;
            ReqReady  <= 1'b0;
            state_reg <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          SramClk1  <= 1'b1;
          state_reg <= ST_PH1;
        end
        ST_PH1: begin
          SramClk1  <= 1'b0;
          SramClk2  <= 1'b1;
          state_reg <= ST_PH2;
        end
        ST_PH2: begin
          SramClk2 <= 1'b0;
          if (write_reg) begin
            SramClk3  <= 1'b1;
            state_reg <= ST_PH3;
          end else begin
            SramOE    <= 1'b0;
            state_reg <= ST_RDCAP;
          end
        end
        ST_PH3: begin
          SramClk3  <= 1'b0;
          drive_reg <= 1'b0;
          SramRNW   <= 1'b1;
          RspValid  <= 1'b1;
          state_reg <= ST_RESP;
        end
        ST_RDCAP: begin
          RspData   <= SramData;
          SramOE    <= 1'b1;
          RspValid  <= 1'b1;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (RspReady) begin
            RspValid  <= 1'b0;
            ReqReady  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_phase_controller.sv
// Directed bench for sram_phase_controller with a behavioural SRAM on the bus.
module tb_sram_phase_controller;

  logic        Clock;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [10:0] ReqAddr;
  logic [31:0] ReqData;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic        RspErr;
  logic [10:0] SramAdx;
  logic        SramRNW;
  logic        SramOE;
  logic        SramClk1;
  logic        SramClk2;
  logic        SramClk3;
  wire  [31:0] SramData;

  int checks;
  int failures;
  int cyc;

  logic        probe_en;
  logic [31:0] mem [0:2047];

  localparam logic [31:0] PROBE_VAL = 32'h1357_9BDF;

  sram_phase_controller #(.ADDR_W(11), .DATA_W(32)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqWrite (ReqWrite),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspData  (RspData),
    .RspErr   (RspErr),
    .SramAdx  (SramAdx),
    .SramRNW  (SramRNW),
    .SramOE   (SramOE),
    .SramClk1 (SramClk1),
    .SramClk2 (SramClk2),
    .SramClk3 (SramClk3),
    .SramData (SramData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // SRAM model: drives read data while OE is low; bench can also drive a
  // probe pattern to show the controller has released the bus.
  assign SramData = (!SramOE && SramRNW) ? mem[SramAdx] :
                    (probe_en ? PROBE_VAL : 32'hzzzz_zzzz);

  // SRAM model: word written while Clock3 is high with RNW low.
  always @(posedge Clock) begin
    if (SramClk3 && !SramRNW) mem[SramAdx] <= SramData;
  end

  // Advance one cycle and apply the always-on bus rules.
  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    checks++;
    if (($countones({SramClk1, SramClk2, SramClk3}) > 1) ||
        (!SramOE && !SramRNW) ||
        (!SramOE && (SramClk1 || SramClk2 || SramClk3))) begin
      failures++;
      $display("FAIL bus_rules cyc=%0d clk123=%b%b%b oe=%b rnw=%b required one-hot-or-zero strobes, OE low only with RNW=1 and no strobe",
               cyc, SramClk1, SramClk2, SramClk3, SramOE, SramRNW);
    end
  endtask

  // Drive one request with RspReady high. lat counts edges from the accept
  // edge (counted as 1) up to the edge after which RspValid is seen.
  task automatic do_op(input logic wr, input logic [10:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output logic [10:0] adx, output int acc_cyc);
    int n;
    ReqWrite = wr;
    ReqAddr  = addr;
    ReqData  = data;
    ReqValid = 1'b1;
    RspReady = 1'b1;
    n = 0;
    while (!ReqReady && n < 20) begin
      tick();
      n++;
    end
    tick();
    acc_cyc  = cyc;
    ReqValid = 1'b0;
    lat = 1;
    while (!RspValid && lat < 20) begin
      tick();
      lat++;
    end
    rdata = RspData;
    err   = RspErr;
    adx   = SramAdx;
    $display("op wr=%0b addr=%03h wdata=%08h -> rdata=%08h err=%0b lat=%0d", wr, addr, data, rdata, err, lat);
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++;
    if (ReqReady !== 1'b1 || RspValid !== 1'b0 || RspData !== 32'h0 || RspErr !== 1'b0 ||
        SramAdx !== 11'h0 || SramRNW !== 1'b1 || SramOE !== 1'b1 ||
        {SramClk1, SramClk2, SramClk3} !== 3'b000) begin
      failures++;
      $display("FAIL reset_values rdy=%b vld=%b data=%h err=%b adx=%h rnw=%b oe=%b clk=%b%b%b required 1 0 0 0 0 1 1 000",
               ReqReady, RspValid, RspData, RspErr, SramAdx, SramRNW, SramOE, SramClk1, SramClk2, SramClk3);
    end
    probe_en = 1'b1;
    #1;
    checks++;
    if (SramData !== PROBE_VAL) begin
      failures++;
      $display("FAIL reset_bus_release bus=%h required %h", SramData, PROBE_VAL);
    end
    probe_en = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [10:0] adx;
    int          ac;
    do_op(1'b1, 11'h005, 32'hDEAD_BEEF, rd, er, lat, adx, ac);
    checks++;
    if (lat !== 5 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL basic_write lat=%0d err=%b data=%h required 5 0 00000000", lat, er, rd);
    end
    do_op(1'b0, 11'h005, 32'h0, rd, er, lat, adx, ac);
    checks++;
    if (lat !== 5 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_read lat=%0d err=%b data=%h required 5 0 deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [10:0] adx;
    int          ac;
    do_op(1'b1, 11'h3FF, 32'h1234_5678, rd, er, lat, adx, ac);
    do_op(1'b1, 11'h000, 32'hCAFE_F00D, rd, er, lat, adx, ac);
    do_op(1'b0, 11'h3FF, 32'h0, rd, er, lat, adx, ac);
    checks++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      failures++;
      $display("FAIL wrap_read_3ff data=%h err=%b required 12345678 0", rd, er);
    end
    do_op(1'b0, 11'h000, 32'h0, rd, er, lat, adx, ac);
    checks++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      failures++;
      $display("FAIL wrap_read_000 data=%h err=%b required cafef00d 0", rd, er);
    end
  endtask

  task automatic test_err();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [10:0] adx;
    int          ac;
    do_op(1'b1, 11'h005, 32'hA5A5_A5A5, rd, er, lat, adx, ac);
    do_op(1'b0, 11'h405, 32'h0, rd, er, lat, adx, ac);
    checks++;
    if (rd !== 32'hA5A5_A5A5 || er !== 1'b1 || adx !== 11'h005 || lat !== 5) begin
      failures++;
      $display("FAIL err_read data=%h err=%b adx=%h lat=%0d required a5a5a5a5 1 005 5", rd, er, adx, lat);
    end
  endtask

  task automatic test_resp_hold();
    int          n;
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [10:0] adx;
    int          ac;
    ReqWrite = 1'b0;
    ReqAddr  = 11'h005;
    ReqValid = 1'b1;
    RspReady = 1'b0;
    tick();
    ReqValid = 1'b0;
    n = 0;
    while (!RspValid && n < 20) begin
      tick();
      n++;
    end
    // A competing write is offered while the response is stalled.
    ReqWrite = 1'b1;
    ReqData  = 32'h0BAD_0BAD;
    ReqValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RspValid !== 1'b1 || RspData !== 32'hA5A5_A5A5 || RspErr !== 1'b0 || ReqReady !== 1'b0) begin
        failures++;
        $display("FAIL resp_hold i=%0d vld=%b data=%h err=%b rdy=%b required 1 a5a5a5a5 0 0",
                 i, RspValid, RspData, RspErr, ReqReady);
      end
      tick();
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    tick();
    checks++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
      failures++;
      $display("FAIL resp_release vld=%b rdy=%b required 0 1", RspValid, ReqReady);
    end
    do_op(1'b0, 11'h005, 32'h0, rd, er, lat, adx, ac);
    checks++;
    if (rd !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL busy_req_ignored data=%h required a5a5a5a5", rd);
    end
    $display("test_resp_hold done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [10:0] adx;
    int          ac0;
    int          ac1;
    int          ac2;
    do_op(1'b1, 11'h020, 32'h0102_0304, rd, er, lat, adx, ac0);
    do_op(1'b0, 11'h020, 32'h0, rd, er, lat, adx, ac1);
    checks++;
    if (ac1 - ac0 !== 6 || rd !== 32'h0102_0304) begin
      failures++;
      $display("FAIL back_to_back_wr_rd spacing=%0d data=%h required 6 01020304", ac1 - ac0, rd);
    end
    do_op(1'b0, 11'h000, 32'h0, rd, er, lat, adx, ac2);
    checks++;
    if (ac2 - ac1 !== 6 || rd !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL back_to_back_rd_rd spacing=%0d data=%h required 6 cafef00d", ac2 - ac1, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [10:0] adx;
    int          ac;
    do_op(1'b1, 11'h010, 32'h3333_4444, rd, er, lat, adx, ac);
    ReqWrite = 1'b1;
    ReqAddr  = 11'h010;
    ReqData  = 32'h1111_2222;
    ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    tick();
    tick();
    checks++;
    if (SramClk2 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_in_ph2 clk2=%b required 1", SramClk2);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (ReqReady !== 1'b1 || RspValid !== 1'b0 || RspData !== 32'h0 || RspErr !== 1'b0 ||
        SramAdx !== 11'h0 || SramRNW !== 1'b1 || SramOE !== 1'b1 ||
        {SramClk1, SramClk2, SramClk3} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_values rdy=%b vld=%b data=%h err=%b adx=%h rnw=%b oe=%b clk=%b%b%b required 1 0 0 0 0 1 1 000",
               ReqReady, RspValid, RspData, RspErr, SramAdx, SramRNW, SramOE, SramClk1, SramClk2, SramClk3);
    end
    probe_en = 1'b1;
    #1;
    checks++;
    if (SramData !== PROBE_VAL) begin
      failures++;
      $display("FAIL reset_mid_bus_release bus=%h required %h", SramData, PROBE_VAL);
    end
    probe_en = 1'b0;
    tick();
    checks++;
    if (RspValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_resp vld=%b required 0", RspValid);
    end
    do_op(1'b0, 11'h010, 32'h0, rd, er, lat, adx, ac);
    checks++;
    if (rd !== 32'h3333_4444) begin
      failures++;
      $display("FAIL reset_mid_write_lost data=%h required 33334444", rd);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    probe_en = 1'b0;
    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqAddr  = '0;
    ReqData  = '0;
    RspReady = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_err();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
